// File: rtl/long_adder_unloader.sv
// long_adder_unloader
//
// Companion block to the long adder core. It follows a single launched
// addition through the core's fixed pipeline latency, captures the SIZE-bit
// sum on the cycle it becomes valid, and then streams it out least-significant
// word first over a valid/ready interface. While an addition is in flight or
// its result is still draining, further launches are refused.
//
// Ports
//   clk           single clock
//   rst           synchronous, active-high reset
//   launch_valid  requester presents operands to the core this cycle
//   launch_ready  a launch is accepted this cycle (IDLE only)
//   sum_in        core dout, valid LATENCY cycles after the launch
//   out_valid     out_data carries a valid beat
//   out_ready     consumer accepts the beat
//   out_data      current beat, 0 when not streaming
//   out_last      current beat is the most significant word
//   sum_count     number of sums fully drained, wraps at 16 bits
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready for a launch
// WAIT   | addition in flight, wait counter counting down to 0
// STREAM | holding buffer loaded, presenting beats LSW first

module long_adder_unloader #(
    parameter int SIZE    = 1024,
    parameter int WORD    = 64,
    parameter int LATENCY = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            launch_valid,
    output logic            launch_ready,
    input  logic [SIZE-1:0] sum_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WORD-1:0] out_data,
    output logic            out_last,
    output logic [15:0]     sum_count
);

    localparam int BEATS = SIZE / WORD;
    localparam int WCW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [WCW-1:0] WAIT_LOAD = WCW'(LATENCY - 1);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t          state;
    logic [SIZE-1:0] buffer;
    logic [WCW-1:0]  wait_cnt;
    logic [BCW-1:0]  beat_cnt;

    // out_valid is registered and high exactly in STREAM, so gating the low
    // word with it keeps out_data at 0 everywhere else without an extra clear.
    assign out_data = out_valid ? buffer[WORD-1:0] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            buffer       <= '0;
            wait_cnt     <= '0;
            beat_cnt     <= '0;
            sum_count    <= '0;
            launch_ready <= 1'b1;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch_valid) begin
                        wait_cnt     <= WAIT_LOAD;
                        launch_ready <= 1'b0;
                        state        <= WAIT;
                    end
                end

                WAIT: begin
                    if (wait_cnt == '0) begin
                        buffer    <= sum_in;
                        beat_cnt  <= '0;
                        out_valid <= 1'b1;
                        out_last  <= (BEATS == 1);
                        state     <= STREAM;
                    end else begin
                        wait_cnt <= wait_cnt - WCW'(1);
                    end
                end

                STREAM: begin
                    if (out_ready) begin
                        if (out_last) begin
                            sum_count    <= sum_count + 16'd1;
                            out_valid    <= 1'b0;
                            out_last     <= 1'b0;
                            launch_ready <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            buffer   <= buffer >> WORD;
                            beat_cnt <= beat_cnt + BCW'(1);
                            out_last <= ((beat_cnt + BCW'(1)) == LAST_BEAT);
                        end
                    end
                end

                default: begin
                    launch_ready <= 1'b1;
                    out_valid    <= 1'b0;
                    out_last     <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_long_adder_unloader.sv
// Bench for long_adder_unloader with SIZE=64, WORD=16, LATENCY=3. A small
// behavioural long adder core (adder followed by pipeline registers) feeds
// sum_in. Expected beats are pushed into a scoreboard queue by the stimulus
// and popped by an independent monitor on every output handshake.

module tb_long_adder_unloader;

    localparam int SIZE    = 64;
    localparam int WORD    = 16;
    localparam int LATENCY = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            launch_valid;
    logic            launch_ready;
    logic [SIZE-1:0] sum_in;
    logic            out_valid;
    logic            out_ready;
    logic [WORD-1:0] out_data;
    logic            out_last;
    logic [15:0]     sum_count;

    logic [SIZE-1:0] din_a, din_b;
    logic [SIZE-1:0] pipe [LATENCY];

    long_adder_unloader #(.SIZE(SIZE), .WORD(WORD), .LATENCY(LATENCY)) dut (
        .clk          (clk),
        .rst          (rst),
        .launch_valid (launch_valid),
        .launch_ready (launch_ready),
        .sum_in       (sum_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .sum_count    (sum_count)
    );

    always #5 clk = ~clk;

    // core model: operands registered at end of launch cycle, sum visible
    // LATENCY cycles after the launch
    always_ff @(posedge clk) begin
        pipe[0] <= din_a + din_b;
        for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
    assign sum_in = pipe[LATENCY-1];

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [WORD-1:0] d;
        logic            l;
    } beat_t;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    beats_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic push4(input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] w2, input logic [15:0] w3);
        beat_t b;
        b.d = w0; b.l = 1'b0; sb.push_back(b);
        b.d = w1; b.l = 1'b0; sb.push_back(b);
        b.d = w2; b.l = 1'b0; sb.push_back(b);
        b.d = w3; b.l = 1'b1; sb.push_back(b);
    endtask

    // monitor: scoreboard pops on handshake, stall stability, idle data zero
    logic            stall_prev = 1'b0;
    logic [WORD-1:0] stall_data;
    logic            stall_last;

    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev) begin
                chk("stall_valid_held", out_valid, 1);
                chk("stall_data_held", out_data, stall_data);
                chk("stall_last_held", out_last, stall_last);
            end
            if (!out_valid) chk("idle_data_zero", out_data, 0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat_sb_size", sb.size(), 1);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    chk("beat_data", out_data, e.d);
                    chk("beat_last", out_last, e.l);
                end
                beats_seen++;
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            stall_last = out_last;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // returns at #1 into cycle T+1, where T is the accept cycle
    task automatic launch(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        int n;
        din_a = a;
        din_b = b;
        launch_valid = 1'b1;
        n = 0;
        while (!launch_ready && n < 100) begin
            tick();
            n++;
        end
        chk("launch_ready_timeout", launch_ready, 1);
        tick();
        launch_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!launch_ready && n < 100);
        chk("drain_timeout", launch_ready, 1);
        chk("scoreboard_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [15:0] rdy_pat [7] = '{1, 0, 0, 1, 0, 1, 1};

    initial begin
        int acc_cyc[$];
        int low_cnt;
        int target;

        rst = 1'b1;
        launch_valid = 1'b0;
        out_ready = 1'b1;
        din_a = '0;
        din_b = '0;
        repeat (3) tick();
        rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_launch_ready", launch_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sum_count", sum_count, 0);
        tick();

        // basic sum with exact cycle timing
        push4(16'hCDEF, 16'h89AB, 16'h4567, 16'h0123);
        launch(64'h0123_4567_89AB_CDEE, 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wait_out_valid", out_valid, 0);
            chk("wait_launch_ready", launch_ready, 0);
            tick();
        end
        @(negedge clk);
        chk("first_beat_at_T4", out_valid, 1);
        chk("stream_launch_ready", launch_ready, 0);
        repeat (3) tick();
        @(negedge clk);
        chk("last_beat_at_T7", out_last, 1);
        chk("last_beat_data", out_data, 16'h0123);
        tick();
        @(negedge clk);
        chk("ready_at_T8", launch_ready, 1);
        chk("sum_count_1", sum_count, 1);
        chk("sb_empty_1", sb.size(), 0);
        tick();

        // same sum with back-pressure
        push4(16'hCDEF, 16'h89AB, 16'h4567, 16'h0123);
        launch(64'h0123_4567_89AB_CDEE, 64'd1);
        repeat (3) tick();
        for (int i = 0; i < 7; i++) begin
            out_ready = rdy_pat[i][0];
            tick();
        end
        out_ready = 1'b1;
        wait_idle();
        chk("sum_count_2", sum_count, 2);

        // carry across every word
        push4(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        launch(64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        wait_idle();
        chk("sum_count_3", sum_count, 3);

        // launch_valid held high: accepts every 8 cycles
        din_a = 64'h0123_4567_89AB_CDEE;
        din_b = 64'd1;
        for (int i = 0; i < 3; i++) push4(16'hCDEF, 16'h89AB, 16'h4567, 16'h0123);
        launch_valid = 1'b1;
        low_cnt = 0;
        for (int c = 0; c < 60 && acc_cyc.size() < 3; c++) begin
            @(negedge clk);
            if (launch_ready) acc_cyc.push_back(cycle);
            else if (acc_cyc.size() > 0) low_cnt++;
            tick();
        end
        launch_valid = 1'b0;
        chk("held_accept_count", acc_cyc.size(), 3);
        if (acc_cyc.size() == 3) begin
            chk("held_spacing_1", acc_cyc[1] - acc_cyc[0], 8);
            chk("held_spacing_2", acc_cyc[2] - acc_cyc[1], 8);
        end
        chk("held_ready_low_cycles", low_cnt, 14);
        wait_idle();
        chk("sum_count_6", sum_count, 6);

        // reset after the second beat
        push4(16'hCDEF, 16'h89AB, 16'h4567, 16'h0123);
        target = beats_seen + 2;
        launch(64'h0123_4567_89AB_CDEE, 64'd1);
        begin
            int n;
            n = 0;
            while (beats_seen < target && n < 50) begin
                tick();
                n++;
            end
            chk("two_beats_timeout", beats_seen >= target, 1);
        end
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_launch_ready", launch_ready, 1);
        chk("midrst_sum_count", sum_count, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_last", out_last, 0);
        tick();
        push4(16'hCDEF, 16'h89AB, 16'h4567, 16'h0123);
        launch(64'h0123_4567_89AB_CDEE, 64'd1);
        wait_idle();
        chk("post_rst_sum_count", sum_count, 1);

        // sum_count wrap
        force dut.sum_count = 16'hFFFF;
        #1;
        release dut.sum_count;
        @(negedge clk);
        chk("preset_sum_count", sum_count, 16'hFFFF);
        tick();
        push4(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        launch(64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        wait_idle();
        chk("sum_count_wrap", sum_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
